// File: rtl/block_sub_pkg.sv
// Shared constants, FSM state type and sizing helper for the serial
// block subtractor.
package block_sub_pkg;

  // Width of one block of the datapath; the sub-block hardware is built for exactly this
  localparam int BLK = 8;

  // Controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of BLK-wide blocks in an n-bit operand
  function automatic int nblk(input int n);
    return n / BLK;
  endfunction

endpackage

// File: rtl/sub_block_bypass.sv
// One BLK-wide slice of a + ~b + cin: ripple sum, group propagate and the
// bypass mux that forwards cin straight to the block carry-out when every
// bit of the block propagates.
module sub_block_bypass
  import block_sub_pkg::*;
(
  input  logic [BLK-1:0] a_blk,
  input  logic [BLK-1:0] b_blk,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout_bypassed,
  output logic           c_into_msb
);

  logic [BLK:0]   c;
  logic [BLK-1:0] nb;
  logic           p;

  // Ripple chain over the inverted subtrahend, group propagate and bypass select
  always_comb begin
    nb   = ~b_blk;
    c    = '0;
    c[0] = cin;
    s    = '0;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = a_blk[i] ^ nb[i] ^ c[i];
      c[i+1] = (a_blk[i] & nb[i]) | (c[i] & (a_blk[i] ^ nb[i]));
    end
    p             = &(a_blk ^ nb);
    cout_bypassed = p ? cin : c[BLK];
    c_into_msb    = c[BLK-1];
  end

endmodule

// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b computed one BLK-wide block per clock
// using a single reused bypass slice. The carry of a + ~b + 1 is kept between
// cycles; the borrow is its inverse. start/busy/done handshake to the
// controller; all results are registered.
module block_serial_subtractor
  import block_sub_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow
);

  localparam int NB = nblk(N);
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic            c_q, c_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BLK-1:0]  a_blk_s;
  logic [BLK-1:0]  b_blk_s;
  logic [BLK-1:0]  s_s;
  logic            cout_s;
  logic            cmsb_s;

  // Select the current block of the latched operands for the shared slice
  always_comb begin
    a_blk_s = a_q[int'(k_q)*BLK +: BLK];
    b_blk_s = b_q[int'(k_q)*BLK +: BLK];
  end

  sub_block_bypass u_blk (
    .a_blk         (a_blk_s),
    .b_blk         (b_blk_s),
    .cin           (c_q),
    .s             (s_s),
    .cout_bypassed (cout_s),
    .c_into_msb    (cmsb_s)
  );

  // Next-state logic: accept in IDLE, one block per cycle in RUN, finish on the last block
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    c_d     = c_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = 1'b1;
          k_d     = '0;
          diff_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: operands stay as latched
        diff_d[int'(k_q)*BLK +: BLK] = s_s;
        c_d = cout_s;
        if (k_q == K_LAST) begin
          bout_d  = ~cout_s;
          ovf_d   = cmsb_s ^ cout_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        k_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; async reset clears everything and aborts a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      c_q     <= c_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Self-checking bench for block_serial_subtractor (N=32). Expected results
// come from plain N-bit arithmetic on the operands.
module tb_block_serial_subtractor;

  localparam int N  = 32;
  localparam int NB = N / 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         overflow;

  int errors;
  int checks;

  block_serial_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: modular difference, unsigned borrow, signed overflow
  function automatic logic [N-1:0] m_diff(input logic [N-1:0] x, input logic [N-1:0] y);
    return x - y;
  endfunction
  function automatic logic m_bout(input logic [N-1:0] x, input logic [N-1:0] y);
    return (x < y);
  endfunction
  function automatic logic m_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] d;
    d = x - y;
    return (x[N-1] != y[N-1]) && (d[N-1] != x[N-1]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    checks++;
    if ({busy, done, bout, overflow} !== 4'b0000 || diff !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [N-1:0] va [6];
    logic [N-1:0] vb [6];
    logic [N-1:0] x, y;
    int lat;
    va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003;
    va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001;
    va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'hFFFF_FFFF;
    va[4] = 32'hFFFF_FFFF; vb[4] = 32'hFFFF_FFFF;
    va[5] = 32'h00FF_00FF; vb[5] = 32'hFF00_FF00;
    for (int t = 0; t < 26; t++) begin
      if (t < 6) begin
        x = va[t];
        y = vb[t];
      end else begin
        x = $urandom;
        y = $urandom;
      end
      start = 1'b1;
      a_in  = x;
      b_in  = y;
      @(negedge clk);
      start = 1'b0;
      a_in  = $urandom;
      b_in  = $urandom;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
        checks++;
        if (busy !== 1'b1 || (lat < NB && (diff >> (lat * 8)) !== '0)) begin
          errors++;
          $display("FAIL arith_busy_phase t=%0d cyc=%0d: busy=%b diff=%h, want busy=1 and blocks>=%0d zero",
                   t, lat, busy, diff, lat);
        end
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== NB) begin
        errors++;
        $display("FAIL arith_latency t=%0d: got %0d, want %0d", t, lat, NB);
      end
      checks++;
      if (diff !== m_diff(x, y) || bout !== m_bout(x, y) || overflow !== m_ovf(x, y) || busy !== 1'b0) begin
        errors++;
        $display("FAIL arith_result a=%h b=%h: got diff=%h bout=%b ovf=%b busy=%b, want diff=%h bout=%b ovf=%b busy=0",
                 x, y, diff, bout, overflow, busy, m_diff(x, y), m_bout(x, y), m_ovf(x, y));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || diff !== m_diff(x, y) || busy !== 1'b0) begin
        errors++;
        $display("FAIL arith_hold a=%h b=%h: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                 x, y, done, busy, diff, m_diff(x, y));
      end
    end
  endtask

  task automatic test_probe();
    logic [N-1:0] x, y;
    logic [7:0] ab, bb;
    logic want_p;
    x = 32'h0000_0000;
    y = 32'h0000_0001;
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < NB; j++) begin
      ab = 8'((x >> (8 * j)) & 32'hFF);
      bb = 8'((y >> (8 * j)) & 32'hFF);
      want_p = ((ab ^ ~bb) == 8'hFF);
      checks++;
      if (dut.u_blk.p !== want_p) begin
        errors++;
        $display("FAIL probe_propagate block=%0d: got p=%b, want %b", j, dut.u_blk.p, want_p);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || diff !== 32'hFFFF_FFFF || bout !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL probe_result: got done=%b diff=%h bout=%b ovf=%b, want 1 ffffffff 1 0",
               done, diff, bout, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [N-1:0] got;
    start = 1'b1;
    a_in  = 32'h0000_0010;
    b_in  = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'h0000_00FF;
    b_in  = 32'h0000_00FF;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    got = '0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) begin
        pulses++;
        got = diff;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignored_start_pulses: got %0d done pulses, want 1", pulses);
    end
    checks++;
    if (got !== 32'h0000_000F) begin
      errors++;
      $display("FAIL ignored_start_diff: got %h, want 0000000f", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] x, y;
    int lat;
    x = $urandom;
    y = $urandom;
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NB || diff !== m_diff(x, y) || bout !== m_bout(x, y)) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d diff=%h bout=%b, want lat=%0d diff=%h bout=%b",
               lat, diff, bout, NB, m_diff(x, y), m_bout(x, y));
    end
    start = 1'b1;
    a_in  = 32'd9;
    b_in  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NB || diff !== '0 || bout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d diff=%h bout=%b ovf=%b, want lat=%0d diff=0 bout=0 ovf=0",
               lat, diff, bout, overflow, NB);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    start = 1'b1;
    a_in  = $urandom;
    b_in  = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bout, overflow} !== 4'b0000 || diff !== '0) begin
      errors++;
      $display("FAIL abort_async: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with busy/done, want 0", pulses);
    end
    start = 1'b1;
    a_in  = 32'd3;
    b_in  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NB || diff !== 32'hFFFF_FFFE || bout !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: lat=%0d diff=%h bout=%b ovf=%b, want lat=%0d diff=fffffffe bout=1 ovf=0",
               lat, diff, bout, overflow, NB);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_arith();
    test_probe();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
